// File: rtl/key_serial_loader.sv
`default_nettype none
// ============================================================================
//  Module      : key_serial_loader
//  Description : Receives a bit-serial key frame (KEY_W key bits MSB-first,
//                then one even-parity bit), checks parity and commits the
//                key to the locked netlist's keyinput bus only on a clean
//                frame. The committed key stays stable between commits.
//                Optional feature macro: KEY_LOCKOUT_EN. When it is defined,
//                MAX_FAIL consecutive parity failures force a lockout that
//                only reset clears.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_serial_loader #(
    parameter int KEY_W    = 32,
    parameter int CNT_W    = 6,
    parameter int MAX_FAIL = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             ser_valid_i,
    input  logic             ser_data_i,
    output logic             ser_ready_o,
    output logic [KEY_W-1:0] key_o,
    output logic             key_valid_o,
    output logic             busy_o,
    output logic             err_o,
    output logic             locked_o
);

    // ST_LOCKED is reachable only when the lockout feature is built in
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_PARITY = 3'd2,
        ST_CHECK  = 3'd3,
        ST_LOCKED = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(KEY_W - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [KEY_W-1:0]   r_shreg;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_par;
    logic [KEY_W-1:0]   r_key;
    logic               r_key_valid;
    logic               w_in_frame;
    logic               w_take;
    logic               w_parity_ok;
    logic               w_lock_now;

    // A bit offered together with an aborting start is discarded
    assign w_in_frame  = (r_state == ST_SHIFT) || (r_state == ST_PARITY);
    assign w_take      = w_in_frame && ser_valid_i && !start_i;
    assign w_parity_ok = ((^r_shreg) ^ r_par) == 1'b0;

    assign ser_ready_o = w_in_frame;
    assign busy_o      = w_in_frame;
    assign key_o       = r_key;
    assign key_valid_o = r_key_valid;

`ifdef KEY_LOCKOUT_EN
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam logic [FAIL_W-1:0] C_FAIL_MAX  = FAIL_W'(MAX_FAIL);
    localparam logic [FAIL_W-1:0] C_FAIL_LAST = FAIL_W'(MAX_FAIL - 1);

    logic [FAIL_W-1:0] r_fail;

    // This failure is the one that reaches the lockout threshold
    assign w_lock_now = (r_state == ST_CHECK) && !w_parity_ok && (r_fail >= C_FAIL_LAST);

    // Saturating count of consecutive parity failures, cleared on a commit
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_fail <= '0;
        end else if (r_state == ST_CHECK) begin
            if (w_parity_ok) begin
                r_fail <= '0;
            end else if (r_fail != C_FAIL_MAX) begin
                r_fail <= r_fail + 1'b1;
            end
        end
    end
`else
    assign w_lock_now = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus the state-derived error and lockout flags
    always_comb begin
        w_next_state = r_state;
        err_o        = 1'b0;
        locked_o     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (start_i) begin
                    w_next_state = ST_SHIFT;
                end else if (w_take && (r_cnt == C_LAST_BIT)) begin
                    w_next_state = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (start_i) begin
                    w_next_state = ST_SHIFT;
                end else if (w_take) begin
                    w_next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                err_o        = !w_parity_ok;
                w_next_state = w_lock_now ? ST_LOCKED : ST_IDLE;
            end
            ST_LOCKED: begin
`ifdef KEY_LOCKOUT_EN
                locked_o     = 1'b1;
                w_next_state = ST_LOCKED;
`else
                w_next_state = ST_IDLE;
`endif
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Frame assembly and key commit; the key bus changes only out of CHECK
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_par       <= 1'b0;
            r_key       <= '0;
            r_key_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_shreg <= '0;
                        r_cnt   <= '0;
                    end
                end
                ST_SHIFT, ST_PARITY: begin
                    if (start_i) begin
                        r_shreg <= '0;
                        r_cnt   <= '0;
                    end else if (w_take) begin
                        if (r_state == ST_SHIFT) begin
                            r_shreg <= {r_shreg[KEY_W-2:0], ser_data_i};
                            r_cnt   <= r_cnt + 1'b1;
                        end else begin
                            r_par   <= ser_data_i;
                        end
                    end
                end
                ST_CHECK: begin
                    if (w_parity_ok) begin
                        r_key       <= r_shreg;
                        r_key_valid <= 1'b1;
                    end else if (w_lock_now) begin
                        r_key       <= '0;
                        r_key_valid <= 1'b0;
                    end
                end
                ST_LOCKED: begin
                    r_key       <= '0;
                    r_key_valid <= 1'b0;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
